// File: rtl/eldritch_pwm_peripheral.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | eldritch_pwm_peripheral: 3-channel PWM, action compares,        |
// | phase sync and per-output deadband. Revision: 1.0 initial       |
// +-----------------------------------------------------------------+
module eldritch_pwm_peripheral #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  localparam int c_NUM_REGS = 49;

  logic [7:0]          r_regs [c_NUM_REGS];
  logic [5:0]          w_addr;
  logic                w_we;
  logic [NUM_CH-1:0]   w_wrap;
  logic                w_sync;
  logic [2*NUM_CH-1:0] w_pwm;
  logic                w_unused;

  assign w_addr   = ui_in[7:2];
  assign w_we     = ui_in[0];
  assign w_sync   = w_wrap[0];
  assign w_unused = &{1'b0, ena, ui_in[1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < c_NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_we && (w_addr < 6'(c_NUM_REGS))) begin
      r_regs[w_addr] <= uio_in;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // CH1 has no phase register, so its output blocks start two bytes earlier
    localparam int c_BASE  = (c == 0) ? 0 : 15 + 17 * (c - 1);
    localparam int c_OBASE = c_BASE + ((c == 0) ? 3 : 5);

    logic [7:0]       w_ctrl;
    logic             w_en;
    logic [CNT_W-1:0] w_period;
    logic [CNT_W-1:0] w_phase;
    logic [CNT_W-1:0] r_cnt;
    logic             w_sync_load;
    logic             w_unused_ctrl;

    assign w_ctrl        = r_regs[c_BASE];
    assign w_en          = w_ctrl[0];
    assign w_period      = CNT_W'({r_regs[c_BASE+1], r_regs[c_BASE+2]});
    assign w_phase       = (c == 0) ? '0 : CNT_W'({r_regs[c_BASE+3], r_regs[c_BASE+4]});
    assign w_wrap[c]     = w_en && (r_cnt >= w_period);
    assign w_sync_load   = (c != 0) && w_ctrl[4] && w_sync;
    assign w_unused_ctrl = &{1'b0, w_ctrl[7:5], w_ctrl[3]};

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (!w_en) begin
        r_cnt <= '0;
      end else if (w_sync_load) begin
        r_cnt <= w_phase;
      end else if (w_wrap[c]) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    for (genvar o = 0; o < 2; o++) begin : g_out
      localparam int c_A = c_OBASE + 6 * o;

      logic [7:0]       w_act;
      logic [7:0]       w_dbcfg;
      logic [CNT_W-1:0] w_cmpa;
      logic [CNT_W-1:0] w_cmpb;
      logic             w_ev_z;
      logic             w_ev_p;
      logic             w_ev_a;
      logic             w_ev_b;
      logic [1:0]       w_code;
      logic             w_raw_nxt;
      logic             r_raw;
      logic             r_db;
      logic [3:0]       r_dbcnt;
      logic [3:0]       w_delay;
      logic             w_mismatch;
      logic             w_out;

      assign w_act   = r_regs[c_A];
      assign w_cmpa  = CNT_W'({r_regs[c_A+1], r_regs[c_A+2]});
      assign w_cmpb  = CNT_W'({r_regs[c_A+3], r_regs[c_A+4]});
      assign w_dbcfg = r_regs[c_A+5];

      assign w_ev_z = (r_cnt == '0);
      assign w_ev_p = (r_cnt == w_period);
      assign w_ev_a = (r_cnt == w_cmpa) && (w_cmpa <= w_period);
      assign w_ev_b = (r_cnt == w_cmpb) && (w_cmpb <= w_period);

      // Later assignments override earlier ones: CMPB > CMPA > ZERO > PERIOD
      always_comb begin
        w_code = 2'b00;
        if (w_ev_p && (w_act[3:2] != 2'b00)) w_code = w_act[3:2];
        if (w_ev_z && (w_act[1:0] != 2'b00)) w_code = w_act[1:0];
        if (w_ev_a && (w_act[5:4] != 2'b00)) w_code = w_act[5:4];
        if (w_ev_b && (w_act[7:6] != 2'b00)) w_code = w_act[7:6];
      end

      always_comb begin
        case (w_code)
          2'b01:   w_raw_nxt = 1'b0;
          2'b10:   w_raw_nxt = 1'b1;
          2'b11:   w_raw_nxt = ~r_raw;
          default: w_raw_nxt = r_raw;
        endcase
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_raw <= 1'b0;
        end else if (!w_en) begin
          r_raw <= 1'b0;
        end else begin
          r_raw <= w_raw_nxt;
        end
      end

      assign w_delay    = r_raw ? w_dbcfg[7:4] : w_dbcfg[3:0];
      assign w_mismatch = (r_raw != r_db);

      // r_dbcnt counts how long raw has disagreed with the deadbanded level
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_db    <= 1'b0;
          r_dbcnt <= '0;
        end else if (!w_mismatch) begin
          r_dbcnt <= '0;
        end else if (({1'b0, r_dbcnt} + 5'd1) >= {1'b0, w_delay}) begin
          r_db    <= r_raw;
          r_dbcnt <= '0;
        end else begin
          r_dbcnt <= r_dbcnt + 4'd1;
        end
      end

      // A zero delay passes raw straight through without the one-clock lag
      assign w_out = (w_mismatch && (w_delay == 4'd0)) ? r_raw : r_db;
      assign w_pwm[2*c+o] = w_out & w_ctrl[1+o] & w_en;
    end
  end

  assign uo_out  = 8'(w_pwm);
  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule
`default_nettype wire

// File: tb/tb_eldritch_pwm_peripheral.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_eldritch_pwm_peripheral: randomized bench with reference     |
// | model for eldritch_pwm_peripheral. Revision: 1.0 initial        |
// +-----------------------------------------------------------------+
module tb_eldritch_pwm_peripheral;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uo_out;

  always #5 clk = ~clk;

  eldritch_pwm_peripheral dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .uo_out  (uo_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: register image, counters, raw levels, settled deadband
  // levels and how many consecutive cycles each raw level has been steady.
  logic [7:0] m_regs [64];
  int         m_cnt  [3];
  bit         m_raw  [3][2];
  bit         m_q    [3][2];
  int         m_run  [3][2];

  function automatic int ch_base(int c);
    return (c == 0) ? 0 : ((c == 1) ? 15 : 32);
  endfunction

  function automatic int out_base(int c, int o);
    return ch_base(c) + ((c == 0) ? 3 : 5) + 6 * o;
  endfunction

  function automatic int rd16(int a);
    return int'({m_regs[a], m_regs[a+1]});
  endfunction

  function automatic int db_delay(int c, int o, bit level);
    logic [7:0] d;
    d = m_regs[out_base(c, o) + 5];
    return level ? int'(d[7:4]) : int'(d[3:0]);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) m_regs[i] = '0;
    for (int c = 0; c < 3; c++) begin
      m_cnt[c] = 0;
      for (int o = 0; o < 2; o++) begin
        m_raw[c][o] = 1'b0;
        m_q[c][o]   = 1'b0;
        m_run[c][o] = 1;
      end
    end
  endfunction

  function automatic void model_edge(bit rst_ok, bit we, int addr, int data);
    int         ncnt [3];
    bit         sync;
    int         b;
    int         per;
    bit         en;
    int         a;
    logic [7:0] act;
    int         cmpa;
    int         cmpb;
    int         code;
    bit         hit  [4];
    int         ecode[4];
    bit         nraw;
    if (!rst_ok) begin
      model_reset();
      return;
    end
    sync = m_regs[0][0] && (m_cnt[0] >= rd16(1));
    for (int c = 0; c < 3; c++) begin
      b   = ch_base(c);
      en  = m_regs[b][0];
      per = rd16(b + 1);
      if (!en)                               ncnt[c] = 0;
      else if (c > 0 && m_regs[b][4] && sync) ncnt[c] = rd16(b + 3);
      else if (m_cnt[c] >= per)              ncnt[c] = 0;
      else                                   ncnt[c] = m_cnt[c] + 1;
      for (int o = 0; o < 2; o++) begin
        a    = out_base(c, o);
        act  = m_regs[a];
        cmpa = rd16(a + 1);
        cmpb = rd16(a + 3);
        hit   = '{(m_cnt[c] == cmpb) && (cmpb <= per), (m_cnt[c] == cmpa) && (cmpa <= per),
                  m_cnt[c] == 0, m_cnt[c] == per};
        ecode = '{int'(act[7:6]), int'(act[5:4]), int'(act[1:0]), int'(act[3:2])};
        code = 0;
        for (int k = 3; k >= 0; k--) if (hit[k] && ecode[k] != 0) code = ecode[k];
        if (!en)            nraw = 1'b0;
        else if (code == 1) nraw = 1'b0;
        else if (code == 2) nraw = 1'b1;
        else if (code == 3) nraw = ~m_raw[c][o];
        else                nraw = m_raw[c][o];
        if (m_run[c][o] >= db_delay(c, o, m_raw[c][o])) m_q[c][o] = m_raw[c][o];
        m_run[c][o] = (nraw == m_raw[c][o]) ? ((m_run[c][o] < 255) ? m_run[c][o] + 1 : 255) : 1;
        m_raw[c][o] = nraw;
      end
    end
    for (int c = 0; c < 3; c++) m_cnt[c] = ncnt[c];
    if (we && addr < 49) m_regs[addr] = data[7:0];
  endfunction

  function automatic logic [7:0] model_out();
    logic [7:0] r;
    bit         lvl;
    int         b;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      b = ch_base(c);
      for (int o = 0; o < 2; o++) begin
        lvl = (db_delay(c, o, m_raw[c][o]) == 0) ? m_raw[c][o] : m_q[c][o];
        r[2*c+o] = lvl & m_regs[b][1+o] & m_regs[b][0];
      end
    end
    return r;
  endfunction

  int         ones      [8];
  int         rises     [8];
  int         last_rise [8];
  int         last_fall [8];
  int         overlap01;
  int         cyc = 0;
  logic [7:0] prev_uo = '0;

  task automatic clear_stats();
    for (int i = 0; i < 8; i++) begin
      ones[i] = 0; rises[i] = 0; last_rise[i] = 0; last_fall[i] = 0;
    end
    overlap01 = 0;
  endtask

  task automatic tick();
    logic [7:0] exp_uo;
    @(posedge clk);
    model_edge(rst_n, ui_in[0], int'(ui_in[7:2]), int'(uio_in));
    #1;
    exp_uo = model_out();
    check_val("uo_out", uo_out, exp_uo);
    for (int i = 0; i < 8; i++) begin
      if (uo_out[i]) ones[i]++;
      if (uo_out[i] && !prev_uo[i]) begin rises[i]++; last_rise[i] = cyc; end
      if (!uo_out[i] && prev_uo[i]) last_fall[i] = cyc;
    end
    if (uo_out[0] && uo_out[1]) overlap01++;
    prev_uo = uo_out;
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input int a, input int d);
    logic [5:0] a6;
    a6     = a[5:0];
    ui_in  = {a6, 1'($urandom), 1'b1};
    uio_in = d[7:0];
    tick();
    ui_in  = {6'($urandom), 1'($urandom), 1'b0};
    uio_in = 8'($urandom);
  endtask

  task automatic wr16(input int a, input int v);
    wr(a, (v >> 8) & 255);
    wr(a + 1, v & 255);
  endtask

  task automatic prog_ch(input int c);
    int b;
    int a;
    b = ch_base(c);
    wr(b, ($urandom_range(0, 5) == 0) ? int'($urandom) : int'($urandom | 1));
    wr16(b + 1, $urandom_range(0, 40));
    if (c > 0) wr16(b + 3, $urandom_range(0, 45));
    for (int o = 0; o < 2; o++) begin
      a = out_base(c, o);
      wr(a, $urandom);
      wr16(a + 1, $urandom_range(0, 45));
      wr16(a + 3, $urandom_range(0, 45));
      wr(a + 5, $urandom_range(0, 255));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int d;

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = '0;
    uio_in = '0;
    model_reset();
    clear_stats();

    // Long reset with write traffic that must be ignored
    for (int i = 0; i < 400; i++) begin
      ui_in  = 8'($urandom);
      uio_in = 8'($urandom);
      tick();
      if (i % 50 == 0) begin
        check_val("rst_uo", uo_out, 8'h00);
        check_val("rst_uio_oe", uio_oe, 8'h00);
        check_val("rst_uio_out", uio_out, 8'h00);
      end
    end
    ui_in = '0;
    rst_n = 1'b1;
    clear_stats();
    run(100);
    check_val("idle_ones", ones[0] + ones[1] + ones[2] + ones[3] + ones[4] + ones[5], 0);

    // CH1 basic PWM
    wr(8'h00, 8'h17); wr16(8'h01, 16'h001F); wr(8'h03, 8'h12); wr16(8'h04, 16'h0008); wr(8'h08, 8'h00);
    run(70); clear_stats(); run(64);
    check_val("ch1_high", ones[0], 16);
    check_val("ch1_rises", rises[0], 2);

    // CH1 complementary with RED=3 on A
    wr(8'h09, 8'h21); wr16(8'h0A, 16'h0008); wr(8'h08, 8'h30);
    run(70); clear_stats(); run(64);
    check_val("ch1a_db_high", ones[0], 10);
    check_val("ch1b_high", ones[1], 48);
    check_val("ch1_overlap", overlap01, 0);
    check_val("ch1_deadgap", ((last_rise[0] - last_fall[1]) % 32 + 32) % 32, 3);

    // Phase sync: CH2 mirrors CH1 with PHASE=10
    wr(8'h08, 8'h00);
    wr16(8'h10, 16'h001F); wr16(8'h12, 16'h000A); wr(8'h14, 8'h12); wr16(8'h15, 16'h0008);
    wr(8'h0F, 8'h17);
    run(100); clear_stats(); run(64);
    check_val("ch2_high", ones[2], 16);
    check_val("ch2_lead", ((last_rise[0] - last_rise[2]) % 32 + 32) % 32, 10);

    // CH3 enables
    wr16(8'h21, 16'h001F); wr(8'h25, 8'h12); wr16(8'h26, 16'h0008);
    wr(8'h2B, 8'h21); wr16(8'h2C, 16'h0008); wr(8'h20, 8'h07);
    run(70); clear_stats(); run(64);
    check_val("ch3a_high", ones[4], 16);
    check_val("ch3b_high", ones[5], 48);
    wr(8'h20, 8'h05);
    run(40); clear_stats(); run(64);
    check_val("ch3a_oe_off", ones[4], 0);
    check_val("ch3b_oe_on", ones[5], 48);
    wr(8'h20, 8'h00);
    run(40); clear_stats(); run(64);
    check_val("ch3_off_a", ones[4], 0);
    check_val("ch3_off_b", ones[5], 0);
    wr(8'h20, 8'h07);
    check_val("ch3_restart0", uo_out[4], 1'b0);
    tick();
    check_val("ch3_restart1", uo_out[4], 1'b1);

    // Boundaries on CH1 output A
    wr(8'h09, 8'h00); wr(8'h03, 8'h18); wr16(8'h04, 16'h001F);
    run(70); clear_stats(); run(64);
    check_val("cmpa_eq_period", ones[0], 0);
    wr(8'h03, 8'h12); wr16(8'h04, 16'h0040);
    run(70); clear_stats(); run(64);
    check_val("cmpa_gt_period", ones[0], 64);

    // Mid-run reset
    rst_n = 1'b0;
    tick();
    check_val("midrun_rst", uo_out, 8'h00);
    rst_n = 1'b1;
    run(10); clear_stats(); run(64);
    check_val("post_rst_idle", ones[0] + ones[1] + ones[2] + ones[3] + ones[4] + ones[5], 0);

    // Randomized programming, stray writes and occasional resets
    for (int it = 0; it < 24; it++) begin
      prog_ch($urandom_range(0, 2));
      repeat (4) begin
        run($urandom_range(20, 80));
        if ($urandom_range(0, 3) == 0) wr($urandom_range(0, 63), $urandom);
      end
      if ($urandom_range(0, 7) == 0) begin
        rst_n = 1'b0;
        run($urandom_range(1, 3));
        rst_n = 1'b1;
      end
    end
    check_val("end_uio_oe", uio_oe, 8'h00);
    check_val("end_uio_out", uio_out, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
